// File: rtl/ex_longop_ctrl_pkg.sv
// Shared types for the execute-stage long-op controller: FSM states, counter width
// and the latency-to-counter-preload helper.
package ex_longop_ctrl_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY   = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  // Counter preload so that cnt reaches zero exactly in the completion cycle.
  function automatic logic [CNT_W-1:0] cnt_load(input int unsigned lat);
    cnt_load = CNT_W'(lat - 32'd1);
  endfunction

endpackage

// File: rtl/ex_longop_ctrl_hazard_chk.sv
// Scoreboard hazard detect against the single pending long-op destination.
// Only used when EX_SCOREBOARD_EN is defined.
module ex_hazard_chk
  import ex_longop_ctrl_pkg::*;
#(
  parameter int W_RD = 5
) (
  input  logic            v_i,
  input  logic            long_i,
  input  logic            halt_i,
  input  logic            wb_i,
  input  logic [W_RD-1:0] rd_name_i,
  input  logic [W_RD-1:0] rs_name_i,
  input  logic [W_RD-1:0] rt_name_i,
  input  logic [W_RD-1:0] pend_rd_i,
  input  logic            pend_wb_i,
  output logic            hazard_o
);

  logic raw_hit;
  logic waw_hit;

  // RAW on either source, WAW on the destination; a second long op or a halt always waits.
  always_comb begin
    raw_hit  = ((rs_name_i == pend_rd_i) | (rt_name_i == pend_rd_i)) & pend_wb_i;
    waw_hit  = wb_i & (rd_name_i == pend_rd_i) & pend_wb_i;
    hazard_o = v_i & (raw_hit | waw_hit | long_i | halt_i);
  end

endmodule

// File: rtl/ex_longop_ctrl.sv
// Execute-stage issue/writeback controller for one multi-cycle long unit.
// Build option: EX_SCOREBOARD_EN lets independent ALU ops issue while a long op runs.
module ex_longop_ctrl
  import ex_longop_ctrl_pkg::*;
#(
  parameter int WORD = 32,
  parameter int W_RD = 5,
  parameter int LAT  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            v_i,
  input  logic            long_i,
  input  logic            halt_i,
  input  logic            wb_i,
  input  logic [W_RD-1:0] rd_name_i,
  input  logic [W_RD-1:0] rs_name_i,
  input  logic [W_RD-1:0] rt_name_i,
  input  logic [WORD-1:0] alu_data_i,
  input  logic [WORD-1:0] lu_data_i,
  output logic            stall_o,
  output logic            lu_start_o,
  output logic            busy_o,
  output logic            wb_o,
  output logic [W_RD-1:0] wb_rd_name_o,
  output logic [WORD-1:0] wb_rd_data_o
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [W_RD-1:0]   pend_rd_q, pend_rd_d;
  logic              pend_wb_q, pend_wb_d;
  logic              busy_q, busy_d;
  logic              wb_q, wb_d;
  logic [W_RD-1:0]   wb_rd_name_q, wb_rd_name_d;
  logic [WORD-1:0]   wb_rd_data_q, wb_rd_data_d;

  logic              hazard;
  logic              complete;
  logic              stall;
  logic              accept;
  logic              lu_start;

`ifdef EX_SCOREBOARD_EN
  ex_hazard_chk #(
    .W_RD (W_RD)
  ) u_hazard (
    .v_i       (v_i),
    .long_i    (long_i),
    .halt_i    (halt_i),
    .wb_i      (wb_i),
    .rd_name_i (rd_name_i),
    .rs_name_i (rs_name_i),
    .rt_name_i (rt_name_i),
    .pend_rd_i (pend_rd_q),
    .pend_wb_i (pend_wb_q),
    .hazard_o  (hazard)
  );
`else
  logic unused_src_names;
  assign unused_src_names = ^{rs_name_i, rt_name_i};
  assign hazard = v_i;
`endif

  // Stall, accept and launch decode.
  always_comb begin
    complete = (state_q == S_BUSY) && (cnt_q == '0);
    case (state_q)
      S_IDLE:   stall = 1'b0;
      S_BUSY: begin
        // Completion cycle owns the write port, so nothing may issue.
        if (complete) stall = 1'b1;
        else          stall = hazard;
      end
      S_HALTED: stall = 1'b1;
      default:  stall = 1'b1;
    endcase
    accept   = v_i & ~stall;
    lu_start = accept & long_i & ~halt_i & (state_q == S_IDLE);
  end

  // Next FSM state, countdown and pending-destination tracking.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_rd_d = pend_rd_q;
    pend_wb_d = pend_wb_q;
    case (state_q)
      S_IDLE: begin
        if (accept && halt_i) begin
          state_d = S_HALTED;
        end else if (lu_start) begin
          state_d   = S_BUSY;
          cnt_d     = cnt_load(LAT);
          pend_rd_d = rd_name_i;
          pend_wb_d = wb_i;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (complete) state_d = S_IDLE;
        else          cnt_d   = cnt_q - CNT_W'(1);
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_BUSY);
  end

  // Write-port mux: long-unit completion has priority over same-cycle ALU results.
  always_comb begin
    wb_d         = 1'b0;
    wb_rd_name_d = wb_rd_name_q;
    wb_rd_data_d = wb_rd_data_q;
    if (complete && pend_wb_q) begin
      wb_d         = 1'b1;
      wb_rd_name_d = pend_rd_q;
      wb_rd_data_d = lu_data_i;
    end else if (accept && wb_i && !long_i && !halt_i) begin
      wb_d         = 1'b1;
      wb_rd_name_d = rd_name_i;
      wb_rd_data_d = alu_data_i;
    end else begin
      wb_d = 1'b0;
    end
  end

  // State and registered outputs; reset aborts any long op in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      pend_rd_q    <= '0;
      pend_wb_q    <= 1'b0;
      busy_q       <= 1'b0;
      wb_q         <= 1'b0;
      wb_rd_name_q <= '0;
      wb_rd_data_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_rd_q    <= pend_rd_d;
      pend_wb_q    <= pend_wb_d;
      busy_q       <= busy_d;
      wb_q         <= wb_d;
      wb_rd_name_q <= wb_rd_name_d;
      wb_rd_data_q <= wb_rd_data_d;
    end
  end

  assign stall_o      = stall;
  assign lu_start_o   = lu_start;
  assign busy_o       = busy_q;
  assign wb_o         = wb_q;
  assign wb_rd_name_o = wb_rd_name_q;
  assign wb_rd_data_o = wb_rd_data_q;

endmodule

// File: tb/tb_ex_longop_ctrl.sv
// Directed self-checking bench for ex_longop_ctrl with LAT=4; expectations follow
// whichever EX_SCOREBOARD_EN build is compiled.
module tb_ex_longop_ctrl;

  localparam int WORD = 32;
  localparam int W_RD = 5;
  localparam int LAT  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            v_i, long_i, halt_i, wb_i;
  logic [W_RD-1:0] rd_name_i, rs_name_i, rt_name_i;
  logic [WORD-1:0] alu_data_i, lu_data_i;
  logic            stall_o, lu_start_o, busy_o, wb_o;
  logic [W_RD-1:0] wb_rd_name_o;
  logic [WORD-1:0] wb_rd_data_o;

  int n_chk = 0;
  int n_bad = 0;
  int waited;

  ex_longop_ctrl #(.WORD(WORD), .W_RD(W_RD), .LAT(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .v_i          (v_i),
    .long_i       (long_i),
    .halt_i       (halt_i),
    .wb_i         (wb_i),
    .rd_name_i    (rd_name_i),
    .rs_name_i    (rs_name_i),
    .rt_name_i    (rt_name_i),
    .alu_data_i   (alu_data_i),
    .lu_data_i    (lu_data_i),
    .stall_o      (stall_o),
    .lu_start_o   (lu_start_o),
    .busy_o       (busy_o),
    .wb_o         (wb_o),
    .wb_rd_name_o (wb_rd_name_o),
    .wb_rd_data_o (wb_rd_data_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    v_i = 1'b0; long_i = 1'b0; halt_i = 1'b0; wb_i = 1'b0;
    rd_name_i = 5'd0; rs_name_i = 5'd0; rt_name_i = 5'd0;
    alu_data_i = 32'd0;
    #1;
  endtask

  task automatic op(input logic a_long, input logic a_halt, input logic a_wb,
                    input logic [4:0] a_rd, input logic [4:0] a_rs, input logic [4:0] a_rt,
                    input logic [31:0] a_alu);
    v_i = 1'b1; long_i = a_long; halt_i = a_halt; wb_i = a_wb;
    rd_name_i = a_rd; rs_name_i = a_rs; rt_name_i = a_rt;
    alu_data_i = a_alu;
    #1;
  endtask

  // Returns the number of stalled cycles before the held op is accepted (capped at 20).
  task automatic wait_accept(output int n);
    n = 0;
    while (stall_o && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    lu_data_i = 32'd0;
    clr();
    #12;
    chk("rst_stall", stall_o, 1'b0);
    chk("rst_lu_start", lu_start_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_wb", wb_o, 1'b0);
    chk("rst_wb_name", wb_rd_name_o, 5'd0);
    chk("rst_wb_data", wb_rd_data_o, 32'd0);
    @(negedge clk) rst = 1'b1;
    tick();

    // Basic long op rd=3, result 0x1234 in the completion cycle
    op(1'b1, 1'b0, 1'b1, 5'd3, 5'd0, 5'd0, 32'd0);
    chk("l1_start", lu_start_o, 1'b1);
    chk("l1_no_stall", stall_o, 1'b0);
    tick(); clr();
    chk("l1_busy", busy_o, 1'b1);
    chk("l1_start_pulse", lu_start_o, 1'b0);
    tick(); tick();
    chk("l1_idle_id_nostall", stall_o, 1'b0);
    tick();
    lu_data_i = 32'h1234; #1;
    chk("l1_complete_stall", stall_o, 1'b1);
    chk("l1_complete_busy", busy_o, 1'b1);
    tick();
    lu_data_i = 32'd0;
    chk("l1_wb", wb_o, 1'b1);
    chk("l1_wb_name", wb_rd_name_o, 5'd3);
    chk("l1_wb_data", wb_rd_data_o, 32'h1234);
    chk("l1_busy_done", busy_o, 1'b0);
    tick();
    chk("l1_wb_off", wb_o, 1'b0);
    chk("l1_name_hold", wb_rd_name_o, 5'd3);

    // Long rd=3 followed by an independent ALU op, then a dependent one
    lu_data_i = 32'h5678;
    op(1'b1, 1'b0, 1'b1, 5'd3, 5'd0, 5'd0, 32'd0);
    tick();
    op(1'b0, 1'b0, 1'b1, 5'd5, 5'd1, 5'd2, 32'hAA);
    wait_accept(waited);
`ifdef EX_SCOREBOARD_EN
    chk("sb_indep_wait", waited, 0);
    tick();
    chk("sb_alu_wb", wb_o, 1'b1);
    chk("sb_alu_name", wb_rd_name_o, 5'd5);
    chk("sb_alu_data", wb_rd_data_o, 32'hAA);
    op(1'b0, 1'b0, 1'b1, 5'd6, 5'd3, 5'd0, 32'hBB);
    wait_accept(waited);
    chk("sb_raw_wait", waited, 3);
    chk("sb_long_wb_name", wb_rd_name_o, 5'd3);
    chk("sb_long_wb_data", wb_rd_data_o, 32'h5678);
    tick(); clr();
    chk("sb_dep_wb", wb_o, 1'b1);
    chk("sb_dep_name", wb_rd_name_o, 5'd6);
    chk("sb_dep_data", wb_rd_data_o, 32'hBB);
`else
    chk("blk_wait", waited, 4);
    chk("blk_long_wb", wb_o, 1'b1);
    chk("blk_long_wb_name", wb_rd_name_o, 5'd3);
    chk("blk_long_wb_data", wb_rd_data_o, 32'h5678);
    tick(); clr();
    chk("blk_alu_wb", wb_o, 1'b1);
    chk("blk_alu_name", wb_rd_name_o, 5'd5);
    chk("blk_alu_data", wb_rd_data_o, 32'hAA);
`endif
    tick();
    chk("s2_wb_off", wb_o, 1'b0);

    // Second long op while busy; it has wb_i=0 so it never writes
    op(1'b1, 1'b0, 1'b1, 5'd9, 5'd0, 5'd0, 32'd0);
    tick();
    op(1'b1, 1'b0, 1'b0, 5'd10, 5'd0, 5'd0, 32'd0);
    chk("l2_busy_stall", stall_o, 1'b1);
    chk("l2_busy_no_start", lu_start_o, 1'b0);
    wait_accept(waited);
    chk("l2_wait", waited, 4);
    chk("l2_start", lu_start_o, 1'b1);
    chk("l2_prev_wb_name", wb_rd_name_o, 5'd9);
    tick(); clr();
    chk("l2_busy", busy_o, 1'b1);
    tick(); tick(); tick();
    chk("l2_complete_stall", stall_o, 1'b1);
    tick();
    chk("l2_nowb", wb_o, 1'b0);
    chk("l2_busy_done", busy_o, 1'b0);

    // Reset mid long op: abort, no late writeback, fresh ALU op works
    op(1'b1, 1'b0, 1'b1, 5'd4, 5'd0, 5'd0, 32'd0);
    tick(); clr();
    tick();
    rst = 1'b0; #1;
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_wb_name", wb_rd_name_o, 5'd0);
    chk("mid_rst_wb_data", wb_rd_data_o, 32'd0);
    chk("mid_rst_stall", stall_o, 1'b0);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_nowb", wb_o, 1'b0);
    end
    op(1'b0, 1'b0, 1'b1, 5'd7, 5'd0, 5'd0, 32'hCC);
    chk("post_rst_accept", stall_o, 1'b0);
    tick(); clr();
    chk("post_rst_wb", wb_o, 1'b1);
    chk("post_rst_name", wb_rd_name_o, 5'd7);
    chk("post_rst_data", wb_rd_data_o, 32'hCC);

    // Halt while busy: waits for completion, long result still written, then halted
    lu_data_i = 32'h9ABC;
    op(1'b1, 1'b0, 1'b1, 5'd8, 5'd0, 5'd0, 32'd0);
    tick(); clr();
    tick();
    op(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    wait_accept(waited);
    chk("halt_wait", waited, 3);
    chk("halt_long_wb", wb_o, 1'b1);
    chk("halt_long_name", wb_rd_name_o, 5'd8);
    chk("halt_long_data", wb_rd_data_o, 32'h9ABC);
    tick(); clr();
    chk("halted_stall_idle", stall_o, 1'b1);
    op(1'b0, 1'b0, 1'b1, 5'd2, 5'd0, 5'd0, 32'hDD);
    chk("halted_stall_op", stall_o, 1'b1);
    tick();
    chk("halted_nowb", wb_o, 1'b0);
    tick();
    chk("halted_nowb2", wb_o, 1'b0);
    chk("halted_stall_hold", stall_o, 1'b1);
    clr();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_longop_ctrl.md
# ex_longop_ctrl

Issue and writeback controller for the execute stage. It accepts decoded operations from ID, launches multi-cycle (long-latency) operations such as divide into an external long unit, and tracks the pending destination register. It arbitrates the single register-file write port between same-cycle ALU results and long-unit results, and raises stall to ID on structural, data and halt conditions.

## Interface
- `WORD`, 32, data width
- `W_RD`, 5, register-name width
- `LAT`, 16, long-unit latency in cycles from start to result valid; legal range 2..255
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low
- `v_i`  in  1  ID operation valid
- `long_i`  in  1  operation is long-latency (routed to long unit)
- `halt_i`  in  1  operation is HALT
- `wb_i`  in  1  operation writes a register
- `rd_name_i`  in  W_RD  destination register
- `rs_name_i`, `rt_name_i`  in  W_RD  source registers
- `alu_data_i`  in  WORD  single-cycle result for current op
- `lu_data_i`  in  WORD  long-unit result, valid in completion cycle
- `stall_o`  out  1  hold ID; current op not accepted
- `lu_start_o`  out  1  one-cycle launch pulse to long unit
- `busy_o`  out  1  long op in flight
- `wb_o`  out  1  register-file write enable (registered)
- `wb_rd_name_o`  out  W_RD  write register (registered)
- `wb_rd_data_o`  out  WORD  write data (registered)

## Operation
- accept = v_i & ~stall_o. Only accepted ops have effect.
- The FSM has three states:
  - IDLE: accepted long op → `lu_start_o`=1 (combinational, same cycle), latch pend_rd=rd_name_i and pend_wb=wb_i, cnt←LAT-1, go BUSY. An accepted non-long op with wb_i produces an ALU writeback next cycle. An accepted halt_i → HALTED.
  - BUSY: cnt decrements each cycle. Completion cycle is cnt==0: stall_o=1 unconditionally; register writeback of lu_data_i to pend_rd if pend_wb; next state IDLE. In cycles other than completion, stall_o follows hazard rules (Configuration).
  - HALTED: stall_o=1 permanently until reset; no writebacks.
- A long op arriving in BUSY stalls (one long unit). A halt arriving in BUSY stalls until IDLE, then is accepted.
- Register-name compares are exact. r0 is not exempt.
- A long op with wb_i=0 still occupies the unit for LAT cycles and produces no write.
- Writeback mux: a completion-cycle write selects lu_data_i/pend_rd. Otherwise an accepted op with wb_i & ~long_i & ~halt_i selects alu_data_i/rd_name_i. Otherwise wb_o←0, and name/data hold their previous values.

## Timing
- Reset values: stall_o=0, lu_start_o=0, busy_o=0, wb_o=0, wb_rd_name_o=0, wb_rd_data_o=0; FSM=IDLE, cnt=0, pend_rd=0, pend_wb=0.
- Long op accepted in cycle t: lu_start_o high in t, busy_o high t+1..t+LAT, completion cycle t+LAT-1+1=t+LAT (cnt reaches 0), wb_o high in t+LAT+1.
- ALU op accepted in cycle t: wb_o high in t+1.
- The completion-cycle stall guarantees that no write-port collision is possible.
- Asserting reset mid-operation aborts the long op. The late lu_data_i is ignored, and there is no writeback.
- busy_o is registered. stall_o is combinational from state, cnt and ID inputs.

## Configuration
- `EX_SCOREBOARD_EN` defined: in BUSY, non-completion cycles stall only on hazard. The hazard condition is v_i & ((rs_name_i==pend_rd | rt_name_i==pend_rd) & pend_wb | wb_i & rd_name_i==pend_rd & pend_wb | long_i | halt_i). Independent ALU ops issue and write back while the long op runs.
- Undefined: in BUSY, stall_o = v_i (fully blocking). Pend_rd compare logic is absent.

## Structure
- Shared package/params header: FSM state encodings (S_IDLE, S_BUSY, S_HALTED), counter width derived from LAT (8 bits).
- One sub-module is natural: `ex_hazard_chk` (combinational pend_rd compare; instantiated only under `EX_SCOREBOARD_EN`).

## Test plan
- LAT=4, reset then long op rd=3 accepted at t=10, lu_data_i=0x1234 at t=14 → lu_start_o at t=10, stall_o=1 at t=14, wb_o=1, rd=3, data=0x1234 at t=15.
- Scoreboard on: long rd=3 at t=10; ALU op rd=5, rs=1, alu_data=0xAA at t=11 → accepted, write r5=0xAA at t=12. ALU op rs=3 at t=12 → stalled until t=15 accept.
- Scoreboard off: same sequence → ALU rd=5 op stalled t=11..14, accepted t=15, write at t=16.
- Second long op at t=11 while BUSY → stall_o=1 through t=14, accepted t=15, new lu_start_o at t=15.
- Halt at t=12 while BUSY → stall until t=14; long writeback at t=15; HALTED, stall_o=1 thereafter, wb_o=0.
- Reset asserted at t=12 mid long op → all outputs 0. No writeback at t=15. A fresh ALU op after release writes normally.
